// File: rtl/sram_rd_stream.sv
// rtl/sram_rd_stream.sv - SRAM read DMA: command in, one-cycle-latency SRAM reads out as a valid/ready stream.
// Optional abort/aborted ports when SRAM_RD_STREAM_ABORT_EN is defined.
module sram_rd_stream #(
    parameter int AW = 14,
    parameter int DW = 128,
    parameter int LW = 15
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    output logic          enb,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] doutb,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy,
`ifdef SRAM_RD_STREAM_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] issue_rem_q;
    logic [LW-1:0] beat_rem_q;
    logic          inflight_q;
    logic [1:0]    fifo_cnt_q;
    logic [DW-1:0] fifo_mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic          cmd_fire;
    logic          pop;
    logic          abort_fire;
    logic [2:0]    occ;

`ifdef SRAM_RD_STREAM_ABORT_EN
    logic aborted_q;
    assign abort_fire = (state_q == RUN) && abort;
    assign aborted    = aborted_q;
`else
    assign abort_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        m_valid   = (fifo_cnt_q != 2'd0);
        m_data    = fifo_mem_q[rd_ptr_q];
        m_last    = m_valid && (beat_rem_q == LW'(1));
        pop       = m_valid && m_ready;
        cmd_fire  = cmd_valid && cmd_ready;
        // Occupancy after this cycle's pop; issuing keeps FIFO + SRAM register within 2 words.
        occ       = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        enb       = (state_q == RUN) && (issue_rem_q != '0) && (occ < 3'd2) && !abort_fire;
        addrb     = addr_q;
        case (state_q)
            IDLE: if (cmd_fire) state_d = (cmd_len == '0) ? DONE : RUN;
            RUN:  if (abort_fire || (pop && m_last)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q        <= '0;
            issue_rem_q   <= '0;
            beat_rem_q    <= '0;
            inflight_q    <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_q      <= cmd_addr;
                issue_rem_q <= cmd_len;
                beat_rem_q  <= cmd_len;
            end else begin
                if (enb) begin
                    addr_q      <= addr_q + AW'(1);
                    issue_rem_q <= issue_rem_q - LW'(1);
                end
                if (pop) beat_rem_q <= beat_rem_q - LW'(1);
            end
            if (abort_fire) begin
                inflight_q <= 1'b0;
                fifo_cnt_q <= 2'd0;
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
            end else begin
                inflight_q <= enb;
                if (inflight_q) begin
                    fifo_mem_q[wr_ptr_q] <= doutb;
                    wr_ptr_q             <= ~wr_ptr_q;
                end
                if (pop) rd_ptr_q <= ~rd_ptr_q;
                fifo_cnt_q <= occ[1:0];
            end
        end
    end

`ifdef SRAM_RD_STREAM_ABORT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) aborted_q <= 1'b0;
        else       aborted_q <= abort_fire;
    end
`endif

endmodule

// File: doc/sram_rd_stream.md
# sram_rd_stream

Read-side DMA engine for the 16K x 128-bit dual-port SRAM. It accepts a command of start address and word count, drives the SRAM read port (enable, address), absorbs the SRAM's one-cycle registered read latency, and presents the words as a valid/ready stream with last-beat marking and backpressure. It sits between the SRAM read port and downstream consumers. A write-side producer fills the SRAM independently through the write port.

## Interface
Parameters:
- AW, 14, SRAM word-address width
- DW, 128, data width
- LW, 15, command length width (0..16384 words)

Ports:
- clk  in  1  sole clock; SRAM read clock tied to it
- rstn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  AW  start word address
- cmd_len  in  LW  number of words to read
- enb  out  1  SRAM read enable
- addrb  out  AW  SRAM read address
- doutb  in  DW  SRAM read data, valid the cycle after enb
- m_valid  out  1  stream beat valid
- m_ready  in  1  stream beat accept
- m_data  out  DW  beat data
- m_last  out  1  final beat of the command
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle pulse at command completion
- abort  in  1  only when SRAM_RD_STREAM_ABORT_EN is defined
- aborted  out  1  only when SRAM_RD_STREAM_ABORT_EN is defined; pulses with done on abort

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on a cmd_valid && cmd_ready handshake. Latch addr, len; remaining issue count = len, remaining beat count = len.
  - If len == 0: IDLE -> DONE directly.
  - RUN -> DONE on the handshake of the beat with m_last.
  - DONE -> IDLE unconditionally after one cycle. done = 1 only in DONE.
- Read issue in RUN: enb = (issue_rem != 0) && (fifo_cnt + inflight - pop < 2), where pop = m_valid && m_ready. This path is combinational from m_ready by design.
- On issue: addrb = current addr; then addr = (addr + 1) mod 2^AW (0x3FFF wraps to 0x0000); issue_rem decrements.
- inflight counts reads whose data is in the SRAM output register and not yet written into the FIFO (0..1). The sum fifo_cnt + inflight never exceeds 2.
- Output buffer: 2-entry FIFO written with doutb one cycle after enb. m_valid = FIFO not empty; m_data = FIFO head.
- m_last = m_valid && (beat_rem == 1). beat_rem decrements on each pop.
- Words are delivered in address order with no loss or duplication under any m_ready pattern.
- cmd_valid outside IDLE is ignored.

## Timing
- Reset values: cmd_ready=1, enb=0, addrb=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, aborted=0. The FSM is in IDLE; all counters are 0.
- Handshake accepted at edge T: first enb in cycle T+1, doutb in T+2, first m_valid in T+3.
- With m_ready held at 1: one beat per cycle sustained. A len=N command completes with done in cycle T+3+N.
- len=0: done in cycle T+1; busy high for that cycle only; no enb and no m_valid.
- Reset asserted mid-command: all outputs return to reset values immediately (asynchronous). In-flight SRAM data and FIFO contents are discarded. Next command after deassertion behaves normally.
- m_valid, once high, holds with stable m_data and m_last until accepted.

## Configuration
- SRAM_RD_STREAM_ABORT_EN defined: abort and aborted ports exist.
  - abort high in RUN stops issue the same cycle and flushes FIFO and inflight data. m_valid drops the next cycle; the FSM enters DONE, and done and aborted pulse together.
  - abort is ignored in IDLE and DONE.
- Undefined: no abort or aborted ports; every command runs to completion.

## Test plan
- Preload mem[0x0010..0x0013]=A0..A3; cmd addr=0x0010 len=4, m_ready=1 -> enb in T+1..T+4 with addrb 0x10..0x13; beats A0..A3 in T+3..T+6; m_last only on A3; done in T+7.
- Same command with m_ready pattern 1,0,0,1,0,1,1 -> exactly A0..A3 in order, m_data stable while stalled, fifo_cnt+inflight ≤ 2 asserted every cycle.
- cmd addr=0x3FFE len=4 -> addrb 0x3FFE,0x3FFF,0x0000,0x0001; m_last on 4th beat.
- cmd len=0 -> done in T+1, no enb, no m_valid, cmd_ready high again in T+2.
- rstn low for 1 cycle after 2nd beat of a len=8 command -> all outputs zero immediately; following len=2 command at 0x0000 returns mem[0], mem[1] correctly.
- With SRAM_RD_STREAM_ABORT_EN: abort during 3rd beat of len=16 with m_ready=0 -> m_valid low next cycle, done=aborted=1 for one cycle, enb low from abort cycle onward.
